// File: rtl/ddr3_mon_pkg.sv
// Shared encodings and sizing helpers for the DDR3 command-bus monitor.
package ddr3_mon_pkg;

    typedef enum logic [3:0] {
        CMD_DESEL = 4'd0,
        CMD_NOP   = 4'd1,
        CMD_ACT   = 4'd2,
        CMD_RD    = 4'd3,
        CMD_WR    = 4'd4,
        CMD_PRE   = 4'd5,
        CMD_PREA  = 4'd6,
        CMD_REF   = 4'd7,
        CMD_MRS   = 4'd8,
        CMD_ZQ    = 4'd9
    } cmd_e;

    // Lower codes take priority when one command breaks several rules.
    typedef enum logic [3:0] {
        ERR_NONE     = 4'd0,
        ERR_CLOSED   = 4'd1,
        ERR_ACT_OPEN = 4'd2,
        ERR_RCD      = 4'd3,
        ERR_RP       = 4'd4,
        ERR_RAS      = 4'd5,
        ERR_REF_OPEN = 4'd6,
        ERR_RFC      = 4'd7
    } err_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned timer_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ddr3_bank_tracker.sv
// One DDR3 bank: open flag plus saturating cycles-since-ACT/PRE timers,
// exposing ready-made timing-constraint comparator results.
module ddr3_bank_tracker
    import ddr3_mon_pkg::*;
#(
    parameter int unsigned T_RCD = 11,
    parameter int unsigned T_RP  = 11,
    parameter int unsigned T_RAS = 28,
    parameter int unsigned TW    = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_act,
    input  logic i_pre,
    output logic o_open,
    output logic o_rcd_ok,
    output logic o_rp_ok,
    output logic o_ras_ok
);

    localparam logic [TW-1:0] SAT = TW'(max2(max2(T_RAS, T_RCD), T_RP));

    logic          r_open;
    logic [TW-1:0] r_since_act;
    logic [TW-1:0] r_since_pre;

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_open      <= 1'b0;
            r_since_act <= SAT;
            r_since_pre <= SAT;
        end else begin
            if (i_act) begin
                r_open      <= 1'b1;
                r_since_act <= '0;
            end else if (r_since_act != SAT) begin
                r_since_act <= r_since_act + 1'b1;
            end
            if (i_pre) begin
                r_open      <= 1'b0;
                r_since_pre <= '0;
            end else if (r_since_pre != SAT) begin
                r_since_pre <= r_since_pre + 1'b1;
            end
        end
    end

    assign o_open   = r_open;
    assign o_rcd_ok = (r_since_act >= TW'(T_RCD));
    assign o_rp_ok  = (r_since_pre >= TW'(T_RP));
    assign o_ras_ok = (r_since_act >= TW'(T_RAS));

endmodule

// File: rtl/ddr3_cmd_monitor.sv
// Passive DDR3 command/address bus monitor: decodes each ck_p edge, tracks
// per-bank state and timing, flags violations and keeps saturating counters.
module ddr3_cmd_monitor
    import ddr3_mon_pkg::*;
#(
    parameter int unsigned ROW_WIDTH  = 14,
    parameter int unsigned BANK_WIDTH = 3,
    parameter int unsigned COL_WIDTH  = 10,
    parameter int unsigned T_RCD      = 11,
    parameter int unsigned T_RP       = 11,
    parameter int unsigned T_RAS      = 28,
    parameter int unsigned T_RFC      = 160,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                       ddr3_ck_p_fpga,
    input  logic                       sys_rst_n,
    input  logic                       ddr3_cke,
    input  logic                       ddr3_cs_n,
    input  logic                       ddr3_ras_n,
    input  logic                       ddr3_cas_n,
    input  logic                       ddr3_we_n,
    input  logic [BANK_WIDTH-1:0]      ddr3_ba,
    input  logic [ROW_WIDTH-1:0]       ddr3_addr,
    input  logic                       init_calib_complete,
    output logic                       cmd_valid,
    output logic [3:0]                 cmd_code,
    output logic [BANK_WIDTH-1:0]      cmd_bank,
    output logic [ROW_WIDTH-1:0]       cmd_row,
    output logic [(1<<BANK_WIDTH)-1:0] bank_open,
    output logic                       err_valid,
    output logic [3:0]                 err_code,
    output logic [BANK_WIDTH-1:0]      err_bank,
    output logic [CNT_WIDTH-1:0]       act_cnt,
    output logic [CNT_WIDTH-1:0]       rd_cnt,
    output logic [CNT_WIDTH-1:0]       wr_cnt,
    output logic [CNT_WIDTH-1:0]       pre_cnt,
    output logic [CNT_WIDTH-1:0]       ref_cnt,
    output logic [CNT_WIDTH-1:0]       err_cnt
);

    localparam int unsigned NUM_BANKS = 1 << BANK_WIDTH;
    localparam int unsigned TW        = timer_width(max2(max2(max2(T_RAS, T_RCD), T_RP), T_RFC));
    localparam logic [TW-1:0] RFC_SAT = TW'(T_RFC);

    // Elaboration guard: A10 must exist for PREA, and the column must leave room for A10/A12.
    if ((ROW_WIDTH < 11) || (COL_WIDTH + 2 > ROW_WIDTH)) begin : g_geometry_check
        $error("ddr3_cmd_monitor: ROW_WIDTH/COL_WIDTH combination unsupported");
    end

    cmd_e                  w_cmd;
    logic                  w_valid;
    logic                  w_is_rdwr;
    logic                  w_rfc_ok;
    logic [NUM_BANKS-1:0]  w_open;
    logic [NUM_BANKS-1:0]  w_rcd_ok;
    logic [NUM_BANKS-1:0]  w_rp_ok;
    logic [NUM_BANKS-1:0]  w_ras_ok;
    logic [NUM_BANKS-1:0]  w_ras_viol;
    logic [BANK_WIDTH-1:0] w_low_ras;
    logic [BANK_WIDTH-1:0] w_low_open;
    err_e                  w_err;
    logic [BANK_WIDTH-1:0] w_err_bank;
    logic                  w_report;

    logic                  r_cmd_valid;
    logic [3:0]            r_cmd_code;
    logic [BANK_WIDTH-1:0] r_cmd_bank;
    logic [ROW_WIDTH-1:0]  r_cmd_row;
    logic                  r_err_valid;
    logic [3:0]            r_err_code;
    logic [BANK_WIDTH-1:0] r_err_bank;
    logic [TW-1:0]         r_since_ref;
    logic [CNT_WIDTH-1:0]  r_act_cnt, r_rd_cnt, r_wr_cnt, r_pre_cnt, r_ref_cnt, r_err_cnt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_cmd = CMD_DESEL;
        if (ddr3_cke && !ddr3_cs_n) begin
            case ({ddr3_ras_n, ddr3_cas_n, ddr3_we_n})
                3'b111:  w_cmd = CMD_NOP;
                3'b011:  w_cmd = CMD_ACT;
                3'b101:  w_cmd = CMD_RD;
                3'b100:  w_cmd = CMD_WR;
                3'b010:  w_cmd = ddr3_addr[10] ? CMD_PREA : CMD_PRE;
                3'b001:  w_cmd = CMD_REF;
                3'b000:  w_cmd = CMD_MRS;
                default: w_cmd = CMD_ZQ;
            endcase
        end
    end

    assign w_valid    = (w_cmd != CMD_DESEL) && (w_cmd != CMD_NOP);
    assign w_is_rdwr  = (w_cmd == CMD_RD) || (w_cmd == CMD_WR);
    assign w_rfc_ok   = (r_since_ref >= RFC_SAT);
    assign w_ras_viol = w_open & ~w_ras_ok;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        ddr3_bank_tracker #(
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS),
            .TW    (TW)
        ) u_tracker (
            .i_clk    (ddr3_ck_p_fpga),
            .i_rst_n  (sys_rst_n),
            .i_act    ((w_cmd == CMD_ACT) && (ddr3_ba == BANK_WIDTH'(g))),
            .i_pre    (((w_cmd == CMD_PRE) && (ddr3_ba == BANK_WIDTH'(g))) || (w_cmd == CMD_PREA)),
            .o_open   (w_open[g]),
            .o_rcd_ok (w_rcd_ok[g]),
            .o_rp_ok  (w_rp_ok[g]),
            .o_ras_ok (w_ras_ok[g])
        );
    end

    // Descending scan so the lowest-numbered flagged bank is the one left standing.
    always_comb begin
        w_low_ras  = '0;
        w_low_open = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (w_ras_viol[i]) w_low_ras  = BANK_WIDTH'(i);
            if (w_open[i])     w_low_open = BANK_WIDTH'(i);
        end
    end

    always_comb begin
        w_err      = ERR_NONE;
        w_err_bank = ddr3_ba;
        if (w_is_rdwr && !w_open[ddr3_ba]) begin
            w_err = ERR_CLOSED;
        end else if ((w_cmd == CMD_ACT) && w_open[ddr3_ba]) begin
            w_err = ERR_ACT_OPEN;
        end else if (w_is_rdwr && !w_rcd_ok[ddr3_ba]) begin
            w_err = ERR_RCD;
        end else if ((w_cmd == CMD_ACT) && !w_rp_ok[ddr3_ba]) begin
            w_err = ERR_RP;
        end else if ((w_cmd == CMD_PRE) && w_ras_viol[ddr3_ba]) begin
            w_err = ERR_RAS;
        end else if ((w_cmd == CMD_PREA) && (|w_ras_viol)) begin
            w_err      = ERR_RAS;
            w_err_bank = w_low_ras;
        end else if ((w_cmd == CMD_REF) && (|w_open)) begin
            w_err      = ERR_REF_OPEN;
            w_err_bank = w_low_open;
        end else if (w_valid && !w_rfc_ok) begin
            w_err = ERR_RFC;
        end
    end

    assign w_report = init_calib_complete && (w_err != ERR_NONE);

    always_ff @(posedge ddr3_ck_p_fpga) begin
        if (!sys_rst_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= '0;
            r_cmd_bank  <= '0;
            r_cmd_row   <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= '0;
            r_err_bank  <= '0;
            r_since_ref <= RFC_SAT;
            r_act_cnt   <= '0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_pre_cnt   <= '0;
            r_ref_cnt   <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_cmd_valid <= w_valid;
            r_cmd_code  <= w_cmd;
            r_cmd_bank  <= ddr3_ba;
            r_cmd_row   <= ddr3_addr;
            r_err_valid <= w_report;
            r_err_code  <= w_report ? w_err : ERR_NONE;
            r_err_bank  <= w_report ? w_err_bank : '0;

            if (w_cmd == CMD_REF)
                r_since_ref <= '0;
            else if (r_since_ref != RFC_SAT)
                r_since_ref <= r_since_ref + 1'b1;

            if ((w_cmd == CMD_ACT) && (r_act_cnt != '1)) r_act_cnt <= r_act_cnt + 1'b1;
            if ((w_cmd == CMD_RD)  && (r_rd_cnt  != '1)) r_rd_cnt  <= r_rd_cnt + 1'b1;
            if ((w_cmd == CMD_WR)  && (r_wr_cnt  != '1)) r_wr_cnt  <= r_wr_cnt + 1'b1;
            if (((w_cmd == CMD_PRE) || (w_cmd == CMD_PREA)) && (r_pre_cnt != '1))
                r_pre_cnt <= r_pre_cnt + 1'b1;
            if ((w_cmd == CMD_REF) && (r_ref_cnt != '1)) r_ref_cnt <= r_ref_cnt + 1'b1;
            if (w_report && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign cmd_bank  = r_cmd_bank;
    assign cmd_row   = r_cmd_row;
    assign bank_open = w_open;
    assign err_valid = r_err_valid;
    assign err_code  = r_err_code;
    assign err_bank  = r_err_bank;
    assign act_cnt   = r_act_cnt;
    assign rd_cnt    = r_rd_cnt;
    assign wr_cnt    = r_wr_cnt;
    assign pre_cnt   = r_pre_cnt;
    assign ref_cnt   = r_ref_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ddr3_cmd_monitor.sv
// Bench for ddr3_cmd_monitor: a timestamp-based reference model checked every
// cycle, plus literal expectations at the key points of each directed scenario.
module tb_ddr3_cmd_monitor;

    localparam int T_RCD = 11;
    localparam int T_RP  = 11;
    localparam int T_RAS = 28;
    localparam int T_RFC = 160;
    localparam int FAR   = -1000000;

    localparam logic [3:0] B_NOP = 4'b0111;
    localparam logic [3:0] B_ACT = 4'b0011;
    localparam logic [3:0] B_RD  = 4'b0101;
    localparam logic [3:0] B_WR  = 4'b0100;
    localparam logic [3:0] B_PRE = 4'b0010;
    localparam logic [3:0] B_REF = 4'b0001;
    localparam logic [3:0] B_MRS = 4'b0000;
    localparam logic [3:0] B_ZQ  = 4'b0110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cke = 1'b1;
    logic        cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [2:0]  ba = '0;
    logic [13:0] addr = '0;
    logic        calib = 1'b0;

    logic        cmd_valid, err_valid;
    logic [3:0]  cmd_code, err_code;
    logic [2:0]  cmd_bank, err_bank;
    logic [13:0] cmd_row;
    logic [7:0]  bank_open;
    logic [31:0] act_cnt, rd_cnt, wr_cnt, pre_cnt, ref_cnt, err_cnt;

    ddr3_cmd_monitor dut (
        .ddr3_ck_p_fpga      (clk),
        .sys_rst_n           (rst_n),
        .ddr3_cke            (cke),
        .ddr3_cs_n           (cs_n),
        .ddr3_ras_n          (ras_n),
        .ddr3_cas_n          (cas_n),
        .ddr3_we_n           (we_n),
        .ddr3_ba             (ba),
        .ddr3_addr           (addr),
        .init_calib_complete (calib),
        .cmd_valid           (cmd_valid),
        .cmd_code            (cmd_code),
        .cmd_bank            (cmd_bank),
        .cmd_row             (cmd_row),
        .bank_open           (bank_open),
        .err_valid           (err_valid),
        .err_code            (err_code),
        .err_bank            (err_bank),
        .act_cnt             (act_cnt),
        .rd_cnt              (rd_cnt),
        .wr_cnt              (wr_cnt),
        .pre_cnt             (pre_cnt),
        .ref_cnt             (ref_cnt),
        .err_cnt             (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit err_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    endtask

    // ---------------- reference model ----------------
    int          cyc = 0;
    int          act_t[8];
    int          pre_t[8];
    int          ref_t;
    logic [7:0]  m_open;
    logic        e_valid, e_err_valid;
    logic [3:0]  e_code, e_err_code;
    logic [2:0]  e_bank, e_err_bank;
    logic [13:0] e_row;
    logic [31:0] e_act, e_rd, e_wr, e_pre, e_ref, e_err;

    function automatic logic [3:0] decode(input logic k, input logic [3:0] bus, input logic a10);
        if (!k || bus[3]) return 4'd0;
        case (bus[2:0])
            3'b111:  return 4'd1;
            3'b011:  return 4'd2;
            3'b101:  return 4'd3;
            3'b100:  return 4'd4;
            3'b010:  return a10 ? 4'd6 : 4'd5;
            3'b001:  return 4'd7;
            3'b000:  return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [3:0] c;
        int b, err, eb, prea_low;
        bit vld;
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                act_t[k] = FAR;
                pre_t[k] = FAR;
            end
            ref_t = FAR;
            m_open = '0;
            {e_valid, e_err_valid, e_code, e_err_code, e_bank, e_err_bank, e_row} = '0;
            {e_act, e_rd, e_wr, e_pre, e_ref, e_err} = '0;
        end else begin
            c   = decode(cke, {cs_n, ras_n, cas_n, we_n}, addr[10]);
            b   = int'(ba);
            vld = (c > 4'd1);
            prea_low = -1;
            for (int k = 7; k >= 0; k--)
                if (m_open[k] && (cyc - act_t[k] - 1 < T_RAS)) prea_low = k;
            err = 0;
            eb  = b;
            if ((c == 3 || c == 4) && !m_open[b])                      err = 1;
            else if (c == 2 && m_open[b])                              err = 2;
            else if ((c == 3 || c == 4) && (cyc - act_t[b] - 1 < T_RCD)) err = 3;
            else if (c == 2 && (cyc - pre_t[b] - 1 < T_RP))            err = 4;
            else if (c == 5 && m_open[b] && (cyc - act_t[b] - 1 < T_RAS)) err = 5;
            else if (c == 6 && prea_low >= 0) begin err = 5; eb = prea_low; end
            else if (c == 7 && m_open != 0) begin
                err = 6;
                for (int k = 7; k >= 0; k--) if (m_open[k]) eb = k;
            end
            else if (vld && (cyc - ref_t - 1 < T_RFC))                 err = 7;

            e_valid     = vld;
            e_code      = c;
            e_bank      = ba;
            e_row       = addr;
            e_err_valid = calib && (err != 0);
            e_err_code  = e_err_valid ? 4'(err) : 4'd0;
            e_err_bank  = e_err_valid ? 3'(eb) : 3'd0;
            if (c == 2) e_act++;
            if (c == 3) e_rd++;
            if (c == 4) e_wr++;
            if (c == 5 || c == 6) e_pre++;
            if (c == 7) e_ref++;
            if (e_err_valid) e_err++;

            if (c == 2) begin m_open[b] = 1'b1; act_t[b] = cyc; end
            if (c == 5) begin m_open[b] = 1'b0; pre_t[b] = cyc; end
            if (c == 6) begin
                m_open = '0;
                for (int k = 0; k < 8; k++) pre_t[k] = cyc;
            end
            if (c == 7) ref_t = cyc;
        end
        cyc++;
        #1;
        if (err_valid) err_seen = 1'b1;
        check("cmd_valid", cmd_valid, e_valid);
        check("cmd_code",  cmd_code,  e_code);
        check("bank_open", bank_open, m_open);
        check("err_valid", err_valid, e_err_valid);
        check("err_code",  err_code,  e_err_code);
        check("act_cnt",   act_cnt,   e_act);
        check("rd_cnt",    rd_cnt,    e_rd);
        check("wr_cnt",    wr_cnt,    e_wr);
        check("pre_cnt",   pre_cnt,   e_pre);
        check("ref_cnt",   ref_cnt,   e_ref);
        check("err_cnt",   err_cnt,   e_err);
        if (e_valid) begin
            check("cmd_bank", cmd_bank, e_bank);
            check("cmd_row",  cmd_row,  e_row);
        end
        if (e_err_valid) check("err_bank", err_bank, e_err_bank);
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [3:0] bus, input int bank, input int a);
        logic [31:0] bv, av;
        bv = bank;
        av = a;
        @(negedge clk);
        cke = 1'b1;
        {cs_n, ras_n, cas_n, we_n} = bus;
        ba   = bv[2:0];
        addr = av[13:0];
    endtask

    task automatic nops(input int n);
        repeat (n) issue(B_NOP, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cke = 1'b1;
        {cs_n, ras_n, cas_n, we_n} = B_NOP;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        err_seen = 1'b0;
    endtask

    initial begin
        // Reset state
        calib = 1'b1;
        do_reset();
        check("rst bank_open", bank_open, 8'h00);
        check("rst cmd_valid", cmd_valid, 1'b0);
        check("rst err_cnt",   err_cnt,   32'd0);

        // ACT b2, 11 NOPs, RD b2: tRCD exactly met
        issue(B_ACT, 2, 14'h1A3);
        nops(11);
        issue(B_RD, 2, 14'h010);
        nops(2);
        check("s1 bank_open", bank_open, 8'h04);
        check("s1 act_cnt",   act_cnt,   32'd1);
        check("s1 rd_cnt",    rd_cnt,    32'd1);
        check("s1 no error",  err_seen,  1'b0);

        // RD only 5 cycles after ACT -> tRCD violation
        do_reset();
        issue(B_ACT, 1, 14'h055);
        nops(4);
        issue(B_RD, 1, 14'h020);
        issue(B_NOP, 0, 0);
        check("s2 err_valid", err_valid, 1'b1);
        check("s2 err_code",  err_code,  4'd3);
        check("s2 err_bank",  err_bank,  3'd1);
        check("s2 err_cnt",   err_cnt,   32'd1);

        // PRE 10 cycles after ACT -> tRAS violation; re-ACT 20 later is clean
        do_reset();
        issue(B_ACT, 0, 14'h0AA);
        nops(9);
        issue(B_PRE, 0, 0);
        issue(B_NOP, 0, 0);
        check("s3 pre err_code", err_code, 4'd5);
        check("s3 pre err_bank", err_bank, 3'd0);
        nops(18);
        issue(B_ACT, 0, 14'h0BB);
        issue(B_NOP, 0, 0);
        check("s3 act err_valid", err_valid, 1'b0);
        check("s3 bank0 open",    bank_open[0], 1'b1);

        // ACT b3/b5, PREA @40, REF @52, ACT b3 @100 -> tRFC violation
        do_reset();
        issue(B_ACT, 3, 14'h003);
        issue(B_ACT, 5, 14'h005);
        nops(38);
        issue(B_PRE, 0, 14'h400);
        issue(B_NOP, 0, 0);
        check("s4 prea bank_open", bank_open, 8'h00);
        check("s4 pre_cnt",        pre_cnt,   32'd1);
        check("s4 prea err_valid", err_valid, 1'b0);
        nops(10);
        issue(B_REF, 0, 0);
        issue(B_NOP, 0, 0);
        check("s4 ref err_valid", err_valid, 1'b0);
        nops(46);
        issue(B_ACT, 3, 14'h033);
        issue(B_NOP, 0, 0);
        check("s4 act err_code", err_code, 4'd7);

        // RD to closed bank: masked with calib=0, reported with calib=1
        do_reset();
        calib = 1'b0;
        issue(B_RD, 4, 14'h008);
        issue(B_NOP, 0, 0);
        check("s5 masked err_valid", err_valid, 1'b0);
        check("s5 masked err_cnt",   err_cnt,   32'd0);
        check("s5 masked seen",      err_seen,  1'b0);
        calib = 1'b1;
        issue(B_RD, 4, 14'h008);
        issue(B_NOP, 0, 0);
        check("s5 err_code", err_code, 4'd1);
        check("s5 err_bank", err_bank, 3'd4);
        check("s5 err_cnt",  err_cnt,  32'd1);
        check("s5 rd_cnt",   rd_cnt,   32'd2);

        // CKE low hides an ACT; reset after a real ACT clears everything
        do_reset();
        @(negedge clk);
        cke = 1'b0;
        {cs_n, ras_n, cas_n, we_n} = B_ACT;
        ba = 3'd2;
        issue(B_NOP, 0, 0);
        check("s6 cke0 act_cnt",   act_cnt,   32'd0);
        check("s6 cke0 cmd_valid", cmd_valid, 1'b0);
        issue(B_ACT, 6, 14'h066);
        issue(B_NOP, 0, 0);
        check("s6 bank_open", bank_open, 8'h40);
        check("s6 act_cnt",   act_cnt,   32'd1);
        do_reset();
        issue(B_NOP, 0, 0);
        check("s6 rst bank_open", bank_open, 8'h00);
        check("s6 rst act_cnt",   act_cnt,   32'd0);

        // tRCD one short, then WR, REF with bank open, MRS/ZQ inside tRFC
        do_reset();
        issue(B_ACT, 7, 14'h177);
        nops(10);
        issue(B_RD, 7, 0);
        issue(B_NOP, 0, 0);
        check("s7 rcd-1 err_code", err_code, 4'd3);
        issue(B_WR, 7, 14'h004);
        issue(B_REF, 0, 0);
        issue(B_NOP, 0, 0);
        check("s7 ref err_code", err_code, 4'd6);
        check("s7 ref err_bank", err_bank, 3'd7);
        issue(B_MRS, 0, 14'h012);
        issue(B_ZQ, 0, 14'h400);
        issue(B_NOP, 0, 0);
        check("s7 zq err_code", err_code, 4'd7);
        check("s7 wr_cnt",      wr_cnt,   32'd1);
        nops(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
